// File: rtl/var_bw_mul_pkg.sv
// Shared types and helpers for the variable bit-width multiplier scheduler.
//   LANE_W / OP_W / P_W : narrow lane, operand and product widths
//   sched_state_e       : scheduler FSM states
//   mul_req_t           : one requester's operation (wide flag + operands)
//   lane_place()        : put a narrow operand byte into a port's multiplier lane
//   pack_lanes()        : combine two narrow operands into one parallel-mode operand
package var_bw_mul_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned OP_W   = 16;
    localparam int unsigned P_W    = 32;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        PAIR_WAIT = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic            wide;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } mul_req_t;

    // Port 0 owns the low lane, port 1 the high lane; the unused lane is zeroed.
    function automatic logic [OP_W-1:0] lane_place(input logic port, input logic [OP_W-1:0] v);
        logic [OP_W-1:0] r;
        if (port) r = {v[LANE_W-1:0], {LANE_W{1'b0}}};
        else      r = {{LANE_W{1'b0}}, v[LANE_W-1:0]};
        return r;
    endfunction

    function automatic logic [OP_W-1:0] pack_lanes(input logic [OP_W-1:0] lo,
                                                   input logic [OP_W-1:0] hi);
        return {hi[LANE_W-1:0], lo[LANE_W-1:0]};
    endfunction

endpackage

// File: rtl/var_bw_mul_sched_if.sv
// Bus bundle of the multiplier scheduler: two request/response ports plus the
// shared multiplier operand/result path.
//   slave  : scheduler view (takes requests, drives responses and multiplier)
//   master : environment view (requesters, response sinks, multiplier)
interface var_bw_mul_sched_if;
    import var_bw_mul_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic            req0_wide;
    logic [OP_W-1:0] req0_a;
    logic [OP_W-1:0] req0_b;
    logic            req1_valid;
    logic            req1_ready;
    logic            req1_wide;
    logic [OP_W-1:0] req1_a;
    logic [OP_W-1:0] req1_b;

    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [P_W-1:0]  rsp0_p;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [P_W-1:0]  rsp1_p;

    logic            mul_para_mode;
    logic [OP_W-1:0] mul_a;
    logic [OP_W-1:0] mul_b;
    logic [P_W-1:0]  mul_p;

    modport slave (
        input  req0_valid, req0_wide, req0_a, req0_b,
        input  req1_valid, req1_wide, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_p, rsp1_valid, rsp1_p,
        input  rsp0_ready, rsp1_ready,
        output mul_para_mode, mul_a, mul_b,
        input  mul_p
    );

    modport master (
        output req0_valid, req0_wide, req0_a, req0_b,
        output req1_valid, req1_wide, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_p, rsp1_valid, rsp1_p,
        output rsp0_ready, rsp1_ready,
        input  mul_para_mode, mul_a, mul_b,
        output mul_p
    );

endinterface

// File: rtl/var_bw_mul_rsp_slot.sv
// Per-port result slot: holds one product with a valid/ready handshake and
// tracks whether the port has an operation outstanding.
//   clk, rst     : clock, synchronous active-high reset
//   i_accept     : request of this port accepted this cycle
//   i_capture    : multiplier result for this port available this cycle
//   i_cap_p      : product to capture
//   i_rsp_ready  : consumer takes the result
//   o_rsp_valid  : result valid
//   o_rsp_p      : result value, held while valid and not taken
//   o_busy       : an operation is outstanding (accepted, result not yet popped)
module var_bw_mul_rsp_slot
    import var_bw_mul_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           i_accept,
    input  logic           i_capture,
    input  logic [P_W-1:0] i_cap_p,
    input  logic           i_rsp_ready,
    output logic           o_rsp_valid,
    output logic [P_W-1:0] o_rsp_p,
    output logic           o_busy
);

    logic           r_valid;
    logic           r_busy;
    logic [P_W-1:0] r_p;
    logic           w_pop;

    assign w_pop = r_valid & i_rsp_ready;

    // Accept only happens when not busy, and capture only when the slot is
    // empty, so neither collides with a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_p     <= '0;
        end else begin
            if (i_accept)   r_busy <= 1'b1;
            else if (w_pop) r_busy <= 1'b0;

            if (i_capture) begin
                r_valid <= 1'b1;
                r_p     <= i_cap_p;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_rsp_valid = r_valid;
    assign o_rsp_p     = r_p;
    assign o_busy      = r_busy;

endmodule

// File: rtl/var_bw_mul_sched.sv
// Two-port scheduler sharing one variable bit-width multiplier (one 16x16 or
// two 8x8 products). Concurrent narrow requests are packed into one
// parallel-mode op; a lone narrow request waits up to WAIT_CYCLES for a partner.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/response ports and multiplier operand/result path
// Parameters:
//   WAIT_CYCLES : max cycles a lone narrow request waits for a partner (0 = never)
module var_bw_mul_sched
    import var_bw_mul_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    var_bw_mul_sched_if.slave bus
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    localparam logic [0:0] ST_IDLE      = IDLE;
    localparam logic [0:0] ST_PAIR_WAIT = PAIR_WAIT;

    mul_req_t        w_req [2];
    logic [1:0]      w_elig;
    logic [1:0]      w_busy;
    logic [1:0]      w_acc;
    logic            w_c;
    logic            w_o;

    logic [0:0]      r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic            r_wait_port, w_wait_port_d;
    logic            r_rr, w_rr_d;

    logic [OP_W-1:0] w_iss_a, w_iss_b;
    logic            w_iss_para, w_iss_wide;
    logic [OP_W-1:0] r_mul_a, r_mul_b;
    logic            r_para;
    logic            r_iss_valid;
    logic [1:0]      r_iss_mask;
    logic            r_iss_wide;

    logic [P_W-1:0]  w_cap_p0, w_cap_p1;

    assign w_req[0] = '{wide: bus.req0_wide, a: bus.req0_a, b: bus.req0_b};
    assign w_req[1] = '{wide: bus.req1_wide, a: bus.req1_a, b: bus.req1_b};
    assign w_elig   = {bus.req1_valid & ~w_busy[1], bus.req0_valid & ~w_busy[0]};

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_wait_port_d = r_wait_port;
        w_rr_d        = r_rr;
        w_acc         = 2'b00;
        w_iss_a       = '0;
        w_iss_b       = '0;
        w_iss_para    = 1'b0;
        w_iss_wide    = 1'b0;
        w_c           = 1'b0;
        w_o           = 1'b1;

        // Nothing is accepted while reset is asserted, so ready never lies.
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (&w_elig && !w_req[0].wide && !w_req[1].wide) begin
                        w_acc      = 2'b11;
                        w_iss_a    = pack_lanes(w_req[0].a, w_req[1].a);
                        w_iss_b    = pack_lanes(w_req[0].b, w_req[1].b);
                        w_iss_para = 1'b1;
                    end else if (|w_elig) begin
                        if (r_rr) w_c = w_elig[1] ? 1'b1 : 1'b0;
                        else      w_c = w_elig[0] ? 1'b0 : 1'b1;
                        w_o = ~w_c;
                        if (w_req[w_c].wide) begin
                            w_acc[w_c] = 1'b1;
                            w_iss_a    = w_req[w_c].a;
                            w_iss_b    = w_req[w_c].b;
                            w_iss_wide = 1'b1;
                            w_rr_d     = w_o;
                        end else if (w_elig[w_o] || WAIT_CYCLES == 0) begin
                            // An eligible other port here must be wide, or we'd have packed.
                            w_acc[w_c] = 1'b1;
                            w_iss_a    = lane_place(w_c, w_req[w_c].a);
                            w_iss_b    = lane_place(w_c, w_req[w_c].b);
                            w_iss_para = 1'b1;
                            w_rr_d     = w_o;
                        end else begin
                            w_state_d     = ST_PAIR_WAIT;
                            w_wait_port_d = w_c;
                            w_cnt_d       = '0;
                        end
                    end
                end
                ST_PAIR_WAIT: begin
                    w_c = r_wait_port;
                    w_o = ~w_c;
                    if (!w_elig[w_c]) begin
                        // Waiter withdrew; nothing to issue.
                        w_state_d = ST_IDLE;
                    end else if (w_elig[w_o] && !w_req[w_o].wide) begin
                        w_acc      = 2'b11;
                        w_iss_a    = pack_lanes(w_req[0].a, w_req[1].a);
                        w_iss_b    = pack_lanes(w_req[0].b, w_req[1].b);
                        w_iss_para = 1'b1;
                        w_state_d  = ST_IDLE;
                    end else if (w_elig[w_o] || r_cnt == CNT_LAST) begin
                        w_acc[w_c] = 1'b1;
                        w_iss_a    = lane_place(w_c, w_req[w_c].a);
                        w_iss_b    = lane_place(w_c, w_req[w_c].b);
                        w_iss_para = 1'b1;
                        w_rr_d     = w_o;
                        w_state_d  = ST_IDLE;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wait_port <= 1'b0;
            r_rr        <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_para      <= 1'b0;
            r_iss_valid <= 1'b0;
            r_iss_mask  <= 2'b00;
            r_iss_wide  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_wait_port <= w_wait_port_d;
            r_rr        <= w_rr_d;
            if (|w_acc) begin
                r_mul_a <= w_iss_a;
                r_mul_b <= w_iss_b;
                r_para  <= w_iss_para;
            end
            r_iss_valid <= |w_acc;
            r_iss_mask  <= w_acc;
            r_iss_wide  <= w_iss_wide;
        end
    end

    assign bus.req0_ready    = w_acc[0];
    assign bus.req1_ready    = w_acc[1];
    assign bus.mul_a         = r_mul_a;
    assign bus.mul_b         = r_mul_b;
    assign bus.mul_para_mode = r_para;

    assign w_cap_p0 = r_iss_wide ? bus.mul_p : {16'h0, bus.mul_p[15:0]};
    assign w_cap_p1 = r_iss_wide ? bus.mul_p : {16'h0, bus.mul_p[31:16]};

    var_bw_mul_rsp_slot u_slot0 (
        .clk         (clk),
        .rst         (rst),
        .i_accept    (w_acc[0]),
        .i_capture   (r_iss_valid & r_iss_mask[0]),
        .i_cap_p     (w_cap_p0),
        .i_rsp_ready (bus.rsp0_ready),
        .o_rsp_valid (bus.rsp0_valid),
        .o_rsp_p     (bus.rsp0_p),
        .o_busy      (w_busy[0])
    );

    var_bw_mul_rsp_slot u_slot1 (
        .clk         (clk),
        .rst         (rst),
        .i_accept    (w_acc[1]),
        .i_capture   (r_iss_valid & r_iss_mask[1]),
        .i_cap_p     (w_cap_p1),
        .i_rsp_ready (bus.rsp1_ready),
        .o_rsp_valid (bus.rsp1_valid),
        .o_rsp_p     (bus.rsp1_p),
        .o_busy      (w_busy[1])
    );

endmodule

// File: tb/tb_var_bw_mul_sched.sv
// Self-checking bench for var_bw_mul_sched: a combinational multiplier model,
// a scoreboard of expected products pushed on accept and checked on pop, plus
// directed checks of grants, issued operands, wait timing and reset.
module tb_var_bw_mul_sched;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    var_bw_mul_sched_if bus ();

    var_bw_mul_sched #(
        .WAIT_CYCLES (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: two 8x8 lanes or one 16x16.
    assign bus.mul_p = bus.mul_para_mode ?
        {16'(bus.mul_a[15:8]) * 16'(bus.mul_b[15:8]),
         16'(bus.mul_a[7:0]) * 16'(bus.mul_b[7:0])} :
        32'(bus.mul_a) * 32'(bus.mul_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_prod(input logic w, input logic [15:0] a,
                                             input logic [15:0] b);
        if (w) return 32'(a) * 32'(b);
        return {16'h0, 16'(a[7:0]) * 16'(b[7:0])};
    endfunction

    // Scoreboard and latency tracking.
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          lat0[$];
    int          lat1[$];
    logic        pv0 = 1'b0;
    logic        pv1 = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp0.delete();
            exp1.delete();
            lat0.delete();
            lat1.delete();
            pv0 <= 1'b0;
            pv1 <= 1'b0;
        end else begin
            if (bus.req0_valid && bus.req0_ready) begin
                exp0.push_back(exp_prod(bus.req0_wide, bus.req0_a, bus.req0_b));
                lat0.push_back(cyc);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                exp1.push_back(exp_prod(bus.req1_wide, bus.req1_a, bus.req1_b));
                lat1.push_back(cyc);
            end
            if (bus.rsp0_valid && !pv0) begin
                check("rsp0_expected", 32'(lat0.size() > 0), 1);
                if (lat0.size() > 0) check("rsp0_latency", 32'(cyc - lat0.pop_front()), 2);
            end
            if (bus.rsp1_valid && !pv1) begin
                check("rsp1_expected", 32'(lat1.size() > 0), 1);
                if (lat1.size() > 0) check("rsp1_latency", 32'(cyc - lat1.pop_front()), 2);
            end
            if (bus.rsp0_valid && bus.rsp0_ready && exp0.size() > 0)
                check("rsp0_p", bus.rsp0_p, exp0.pop_front());
            if (bus.rsp1_valid && bus.rsp1_ready && exp1.size() > 0)
                check("rsp1_p", bus.rsp1_p, exp1.pop_front());
            pv0 <= bus.rsp0_valid;
            pv1 <= bus.rsp1_valid;
        end
    end

    task automatic drive(input int p, input logic w, input logic [15:0] a, input logic [15:0] b);
        if (p == 0) begin
            bus.req0_wide = w; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_wide = w; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end
    endtask

    // Waits (bounded) for ready on port p; n = cycles spent before the accept cycle.
    task automatic req_wait(input int p, input int max_cyc, output int n);
        logic rdy;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = (p == 0) ? bus.req0_ready : bus.req1_ready;
            if (rdy) break;
            n++;
            if (n >= max_cyc) begin
                check("req_wait_timeout", 32'(rdy), 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp0.size() + exp1.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs();
        check("rst_req0_ready", 32'(bus.req0_ready), 0);
        check("rst_req1_ready", 32'(bus.req1_ready), 0);
        check("rst_rsp0_valid", 32'(bus.rsp0_valid), 0);
        check("rst_rsp1_valid", 32'(bus.rsp1_valid), 0);
        check("rst_rsp0_p", bus.rsp0_p, 0);
        check("rst_rsp1_p", bus.rsp1_p, 0);
        check("rst_mul_a", 32'(bus.mul_a), 0);
        check("rst_mul_b", 32'(bus.mul_b), 0);
        check("rst_para", 32'(bus.mul_para_mode), 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int grants[$];
        int r0;
        int r1;
        logic a0;
        logic a1;

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_wide = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_wide = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pack: both narrow together.
        drive(0, 1'b0, 16'h0012, 16'h0034);
        drive(1, 1'b0, 16'h00FF, 16'h00FF);
        @(negedge clk);
        check("t1_ready0", 32'(bus.req0_ready), 1);
        check("t1_ready1", 32'(bus.req1_ready), 1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("t1_mul_a", 32'(bus.mul_a), 32'h0000FF12);
        check("t1_mul_b", 32'(bus.mul_b), 32'h0000FF34);
        check("t1_para", 32'(bus.mul_para_mode), 1);
        drain("t1_drain");

        // Wide op.
        drive(0, 1'b1, 16'hFFFF, 16'hFFFF);
        req_wait(0, 10, n);
        check("t2_wait", 32'(n), 0);
        @(negedge clk);
        check("t2_mul_a", 32'(bus.mul_a), 32'h0000FFFF);
        check("t2_para", 32'(bus.mul_para_mode), 0);
        drain("t2_drain");

        // Lone narrow request times out after WAIT_CYCLES.
        drive(0, 1'b0, 16'h0003, 16'h0005);
        req_wait(0, 20, n);
        check("t3_wait", 32'(n), 4);
        @(negedge clk);
        check("t3_mul_a", 32'(bus.mul_a), 32'h00000003);
        check("t3_mul_b", 32'(bus.mul_b), 32'h00000005);
        check("t3_para", 32'(bus.mul_para_mode), 1);
        drain("t3_drain");

        // Late partner arrives two cycles in.
        drive(0, 1'b0, 16'h0002, 16'h0007);
        @(negedge clk);
        check("t4_wait_ready0_c0", 32'(bus.req0_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_wait_ready0_c1", 32'(bus.req0_ready), 0);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 16'h0010, 16'h0010);
        @(negedge clk);
        check("t4_ready0", 32'(bus.req0_ready), 1);
        check("t4_ready1", 32'(bus.req1_ready), 1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("t4_mul_a", 32'(bus.mul_a), 32'h00001002);
        check("t4_mul_b", 32'(bus.mul_b), 32'h00001007);
        drain("t4_drain");

        // Contention from reset: both wide, continuously.
        apply_reset();
        drive(0, 1'b1, 16'h1234, 16'h0101);
        drive(1, 1'b1, 16'hABCD, 16'h0011);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            a0 = bus.req0_ready;
            a1 = bus.req1_ready;
            if (a0) grants.push_back(0);
            if (a1) grants.push_back(1);
            @(posedge clk);
            #1;
            if (a0) bus.req0_a = bus.req0_a + 16'h0111;
            if (a1) bus.req1_a = bus.req1_a + 16'h0203;
        end
        check("t5_grant_count", 32'(grants.size() >= 4), 1);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            check("t5_grant_order", 32'(grants[k]), 32'(k % 2));

        // Backpressure on port 0.
        bus.rsp0_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp0_valid && n < 10);
        check("t5_rsp0_arrives", 32'(bus.rsp0_valid), 1);
        @(posedge clk);
        #1;
        r0 = 0;
        r1 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("t5_rsp0_valid_hold", 32'(bus.rsp0_valid), 1);
            check("t5_rsp0_p_hold", bus.rsp0_p, exp0[0]);
            a0 = bus.req0_ready;
            a1 = bus.req1_ready;
            r0 += int'(a0);
            r1 += int'(a1);
            @(posedge clk);
            #1;
            if (a1) bus.req1_a = bus.req1_a + 16'h0203;
        end
        check("t5_req0_blocked", 32'(r0), 0);
        check("t5_port1_served", 32'(r1 >= 3), 1);
        bus.rsp0_ready = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain("t5_drain");

        // Reset while port 1 waits for a partner and port 0's result is pending.
        bus.rsp0_ready = 1'b0;
        drive(0, 1'b1, 16'h0003, 16'h0004);
        req_wait(0, 10, n);
        drive(1, 1'b0, 16'h0005, 16'h0006);
        @(negedge clk);
        check("t6_ready1_waits", 32'(bus.req1_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_zero_outputs();
        bus.rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b1, 16'h0102, 16'h0304);
        drive(1, 1'b1, 16'h0506, 16'h0708);
        @(negedge clk);
        check("t6_first_grant0", 32'(bus.req0_ready), 1);
        check("t6_first_grant1", 32'(bus.req1_ready), 0);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        req_wait(1, 10, n);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/var_bw_mul_sched.md
Name: var_bw_mul_sched

Overview:
- Two-port scheduler that shares one variable bit-width multiplier between two requesters.
- The multiplier computes either one 16x16 product, or two independent 8x8 products with para_mode=1.
- Packs concurrent 8-bit requests into a single parallel-mode operation; waits a bounded time for a pairing partner before issuing a lone 8-bit op.
- Registers multiplier operands and returns per-port results over valid/ready handshakes.

Parameters:
- WAIT_CYCLES, 4, maximum cycles a lone narrow request waits for a partner; 0 means never wait.
- CNT_W, $clog2(WAIT_CYCLES+1), wait-counter width (derived; not to be overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid / req1_valid  in  1  request valid
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_wide / req1_wide  in  1  1: 16x16 op; 0: 8x8 op on bits [7:0]
- req0_a, req0_b / req1_a, req1_b  in  16  operands
- rsp0_valid / rsp1_valid  out  1  result valid
- rsp0_ready / rsp1_ready  in  1  result consumed
- rsp0_p / rsp1_p  out  32  product; narrow results zero-extended
- mul_para_mode  out  1  to multiplier: 1 = two 8-bit lanes, 0 = 16-bit
- mul_a, mul_b  out  16  to multiplier operands
- mul_p  in  32  from multiplier (combinational)

Behaviour:
- One clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: all outputs 0; FSM=IDLE; rr_ptr=0 (port 0 has priority); busy0=busy1=0; issue stage invalid.
- Eligibility: port n is eligible iff reqn_valid && !busyn.
  - busyn sets on accept.
  - busyn clears when the rspn_valid && rspn_ready pop occurs.
  - Result: one outstanding op per port.
- Handshake rules:
  - Requesters hold valid and payload stable until ready.
  - reqn_ready is combinational from FSM/eligibility and is high only in the accept cycle.
- Lane map (para mode):
  - Low lane: a[7:0]*b[7:0] gives p[15:0]; always port 0.
  - High lane: a[15:8]*b[15:8] gives p[31:16]; always port 1.
- FSM IDLE:
  - Both eligible and both narrow: accept both (pack). Issue a={a1[7:0],a0[7:0]}, b likewise, para=1. rr_ptr unchanged.
  - Otherwise pick the eligible port by rr_ptr priority, called chosen port C.
    - C wide: accept; issue a,b as given, para=1'b0.
    - C narrow, other port eligible and wide: issue C solo.
    - C narrow, other port not eligible, WAIT_CYCLES=0: issue C solo.
    - C narrow, other port not eligible, WAIT_CYCLES>0: go to PAIR_WAIT with W=C, cnt=0; nothing accepted.
  - Any single-port accept sets rr_ptr to the other port.
- FSM PAIR_WAIT (W waiting):
  - Other port eligible narrow: pack, back to IDLE.
  - Else other port eligible wide: issue W solo, back to IDLE.
  - Else cnt==WAIT_CYCLES-1: issue W solo, back to IDLE.
  - Else cnt++.
  - Net timing: a lone request in cycle T is accepted at T+WAIT_CYCLES.
- Solo narrow issue: W's operand bytes go in W's lane; the other lane's bytes are 0; para=1.
- Issue stage:
  - mul_* outputs are registered: loaded on the edge ending the accept cycle, otherwise held.
  - iss_valid, iss_mask[1:0] and iss_wide are registered alongside.
- Capture:
  - On the edge after issue (iss_valid), mul_p is written into the target rsp register(s) and rspn_valid is set.
  - Wide: rsp_p=mul_p. Narrow port 0: {16'h0, mul_p[15:0]}. Narrow port 1: {16'h0, mul_p[31:16]}.
- Latency: rspn_valid rises 2 cycles after the accept cycle.
- The busy rule guarantees the rsp slot is free at capture. rsp is held stable while valid && !ready.
- Reset mid-operation (PAIR_WAIT, issue in flight, rsp pending): everything is discarded, back to reset values; no response is emitted.

Decomposition:
- Package var_bw_mul_pkg holds:
  - typedef sched_state_e {IDLE, PAIR_WAIT};
  - typedef struct mul_req_t {wide, a, b};
  - constants LANE_W=8, OP_W=16, P_W=32.
- Sub-module var_bw_mul_rsp_slot: 32-bit result register with valid/ready and busy tracking, instantiated once per port.

Test Plan:
1. Pack: both narrow in the same cycle, port0 a=0x0012 b=0x0034 and port1 a=0x00FF b=0x00FF -> both ready same cycle; mul_a=0xFF12, mul_b=0xFF34, para=1; two cycles later rsp0_p=0x000003A8, rsp1_p=0x0000FE01.
2. Wide: port0 wide a=0xFFFF b=0xFFFF -> para=0; rsp0_p=0xFFFE0001 two cycles after accept.
3. Timeout: WAIT_CYCLES=4, port0 narrow a=3 b=5 alone at cycle T -> req0_ready only at T+4; mul_a=0x0003, mul_b=0x0005, para=1; rsp0_p=0x0000000F.
4. Late partner: port0 narrow (a=2 b=7) waits; port1 narrow (a=0x10 b=0x10) arrives 2 cycles later -> packed single issue with mul_a=0x1002, mul_b=0x1007; rsp0=0x0E, rsp1=0x100.
5. Contention and backpressure: both ports wide continuously -> grants alternate 0,1,0,... from reset. With rsp0_ready held 0, rsp0 holds its value, req0_ready stays 0 and port 1 keeps being served.
6. Reset in flight: assert rst during PAIR_WAIT while an issue is pending -> next cycle all outputs are 0, no rsp_valid; the first grant after reset goes to port 0.
